// File: rtl/isquare_pipe.sv
// Pipelined integer squarer: res = arg * arg, built as a shift-add chain.
// Each stage consumes BITS_PER_STAGE operand bits, so the latency is WIDTH/BITS_PER_STAGE cycles.
module isquare_pipe #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned BITS_PER_STAGE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arg_vld,
    input  logic [WIDTH-1:0]   arg,
    output logic               res_vld,
    output logic [2*WIDTH-1:0] res,
    output logic [WIDTH-1:0]   res_arg
);

    localparam int unsigned SAFE_BPS   = (BITS_PER_STAGE < 1) ? 1 : BITS_PER_STAGE;
    localparam int unsigned NUM_STAGES = (WIDTH / SAFE_BPS < 1) ? 1 : WIDTH / SAFE_BPS;
    localparam int unsigned RW         = 2 * WIDTH;
    localparam int unsigned IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit          CFG_BAD    = (BITS_PER_STAGE < 1) ? 1'b1
                                       : ((WIDTH % SAFE_BPS) != 0);

    if (CFG_BAD) begin : g_cfg_err
        $error("isquare_pipe: BITS_PER_STAGE must be >= 1 and divide WIDTH");
    end

    for (genvar k = 0; k < int'(NUM_STAGES); k++) begin : g_stage
        logic             vld_in;
        logic [WIDTH-1:0] x_in;
        logic [RW-1:0]    acc_in;
        logic [RW-1:0]    acc_nxt;
        logic             vld_q;
        logic [WIDTH-1:0] x_q;
        logic [RW-1:0]    acc_q;

        if (k == 0) begin : g_head
            assign vld_in = arg_vld;
            assign x_in   = arg;
            assign acc_in = '0;
        end else begin : g_link
            assign vld_in = g_stage[k-1].vld_q;
            assign x_in   = g_stage[k-1].x_q;
            assign acc_in = g_stage[k-1].acc_q;
        end

        // Add the shifted operand for each operand bit owned by this stage.
        always_comb begin
            acc_nxt = acc_in;
            for (int b = 0; b < int'(SAFE_BPS); b++) begin
                if (x_in[IW'(k * int'(SAFE_BPS) + b)]) begin
                    acc_nxt = acc_nxt + (RW'(x_in) << (k * int'(SAFE_BPS) + b));
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
            end else begin
                vld_q <= vld_in;
            end
        end

        // The last stage doubles as the output register, so it alone clears on reset.
        if (k == int'(NUM_STAGES) - 1) begin : g_tail_data
            always_ff @(posedge clk) begin
                if (rst) begin
                    x_q   <= '0;
                    acc_q <= '0;
                end else if (vld_in) begin
                    x_q   <= x_in;
                    acc_q <= acc_nxt;
                end
            end
        end else begin : g_mid_data
            always_ff @(posedge clk) begin
                if (vld_in) begin
                    x_q   <= x_in;
                    acc_q <= acc_nxt;
                end
            end
        end
    end

    assign res_vld = g_stage[NUM_STAGES-1].vld_q;
    assign res     = g_stage[NUM_STAGES-1].acc_q;
    assign res_arg = g_stage[NUM_STAGES-1].x_q;

endmodule

// File: tb/tb_isquare_pipe.sv
// Scoreboard bench for isquare_pipe: one shared stimulus stream drives
// four instances (BITS_PER_STAGE = 1, 2, 4, 16) each checked against arithmetic squares.
module tb_isquare_pipe;

    localparam int unsigned WIDTH = 16;
    localparam int          NDUT  = 4;

    typedef struct {
        int          due;
        logic [15:0] a;
        logic [31:0] sq;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        arg_vld;
    logic [15:0] arg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int bps,
                       input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s bps=%0d got=%0d exp=%0d", name, bps, got, exp);
        end
    endtask

    for (genvar i = 0; i < NDUT; i++) begin : g_dut
        localparam int unsigned BPS = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 4 : 16;
        localparam int          LAT = int'(WIDTH / BPS);

        logic        res_vld;
        logic [31:0] res;
        logic [15:0] res_arg;
        exp_t        q[$];
        int          lcyc     = 0;
        bit          rst_seen = 1'b0;
        logic [31:0] last_res = '0;
        logic [15:0] last_arg = '0;

        isquare_pipe #(.WIDTH(WIDTH), .BITS_PER_STAGE(BPS)) dut (
            .clk     (clk),
            .rst     (rst),
            .arg_vld (arg_vld),
            .arg     (arg),
            .res_vld (res_vld),
            .res     (res),
            .res_arg (res_arg)
        );

        // Reference: every accepted operand reappears squared LAT edges later.
        always @(posedge clk) begin
            longint unsigned a64;
            exp_t e;
            lcyc     = lcyc + 1;
            rst_seen = rst;
            if (rst) begin
                q.delete();
            end else if (arg_vld) begin
                a64   = 64'(arg);
                e.due = lcyc + LAT - 1;
                e.a   = arg;
                e.sq  = 32'(a64 * a64);
                q.push_back(e);
            end
        end

        always @(negedge clk) begin
            exp_t e;
            if (rst_seen) begin
                chk(res_vld == 1'b0, "rst_vld", BPS, 64'(res_vld), 0);
                chk(res == 32'd0, "rst_res", BPS, 64'(res), 0);
                chk(res_arg == 16'd0, "rst_arg", BPS, 64'(res_arg), 0);
                last_res = '0;
                last_arg = '0;
            end else if (res_vld) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_vld", BPS, 64'(res_arg), 0);
                end else begin
                    e = q.pop_front();
                    chk(e.due == lcyc, "latency", BPS, 64'(lcyc), 64'(e.due));
                    chk(res_arg == e.a, "res_arg", BPS, 64'(res_arg), 64'(e.a));
                    chk(res == e.sq, "res", BPS, 64'(res), 64'(e.sq));
                    last_res = e.sq;
                    last_arg = e.a;
                end
            end else begin
                chk(res == last_res, "hold_res", BPS, 64'(res), 64'(last_res));
                chk(res_arg == last_arg, "hold_arg", BPS, 64'(res_arg), 64'(last_arg));
                if (q.size() != 0 && q[0].due <= lcyc) begin
                    e = q.pop_front();
                    chk(1'b0, "missing_vld", BPS, 64'(lcyc), 64'(e.due));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [15:0] a);
        arg_vld = v;
        arg     = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 16'($urandom));
    endtask

    function automatic int pending();
        return g_dut[0].q.size() + g_dut[1].q.size() + g_dut[2].q.size() + g_dut[3].q.size();
    endfunction

    initial begin
        logic [15:0] dir_args[4];
        int          waited;

        dir_args[0] = 16'd0;
        dir_args[1] = 16'd1;
        dir_args[2] = 16'd255;
        dir_args[3] = 16'd65535;

        // Reset held three cycles with a valid operand presented.
        rst     = 1'b1;
        arg_vld = 1'b1;
        arg     = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle(20);

        // Boundary operands as isolated pulses.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, dir_args[i]);
            idle(20);
        end

        // Back-to-back random stream.
        for (int i = 0; i < 1000; i++) drive(1'b1, 16'($urandom));
        idle(20);

        // 40% duty with bubbles.
        for (int i = 0; i < 600; i++) drive(1'($urandom_range(0, 99) < 40), 16'($urandom));
        idle(20);

        // Reset with five operands in flight, then a fresh operand.
        for (int i = 0; i < 5; i++) drive(1'b1, 16'($urandom));
        rst = 1'b1;
        drive(1'b0, 16'd0);
        rst = 1'b0;
        drive(1'b1, 16'd12);
        idle(20);

        waited = 0;
        while (pending() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        chk(pending() == 0, "drain", 0, 64'(pending()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
